// File: rtl/fxp_alu_pipe.sv
// +----------------------------------------------------------------------------+
// | fxp_alu_pipe : two-stage signed fixed-point ALU with valid/ready handshake  |
// | Optional FXP_ALU_SAT_EN macro: clamp on overflow (otherwise wrap)           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module fxp_alu_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        inst_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sat_o
);

  localparam int PROD_W = 2 * DATA_W;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_CLZ = 3'd3;
  localparam logic [2:0] OP_MIN = 3'd4;
  localparam logic [2:0] OP_MAX = 3'd5;
  localparam logic [2:0] OP_ABS = 3'd6;

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [FRAC_W-1:0] HALF    = FRAC_W'(1) << (FRAC_W - 1);

  logic                     adv;

  logic                     s1_valid_q, s1_valid_d;
  logic [2:0]               s1_op_q, s1_op_d;
  logic [DATA_W-1:0]        s1_a_q, s1_a_d;
  logic [DATA_W-1:0]        s1_b_q, s1_b_d;
  logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;

  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     sat_q, sat_d;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic [DATA_W:0]          addsub;
  logic signed [PROD_W-1:0] prod_shift;
  logic                     round_up;
  logic [PROD_W-1:0]        rounded;
  logic                     mul_fits;
  logic [DATA_W-1:0]        clz_cnt;
  logic [DATA_W-1:0]        res;
  logic                     res_sat;

  // Stage 1: capture operands and the full-precision product.
  always_comb begin
    adv        = !out_valid_q || out_ready_i;
    a_ext      = {{DATA_W{src_a_i[DATA_W-1]}}, src_a_i};
    b_ext      = {{DATA_W{src_b_i[DATA_W-1]}}, src_b_i};
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_prod_d  = s1_prod_q;
    if (adv) begin
      s1_valid_d = in_valid_i;
      s1_op_d    = inst_i;
      s1_a_d     = src_a_i;
      s1_b_d     = src_b_i;
      s1_prod_d  = a_ext * b_ext;
    end
  end

  // Stage 2 datapath: round, saturate/wrap and select the result.
  always_comb begin
    if (s1_op_q == OP_SUB) begin
      addsub = {s1_a_q[DATA_W-1], s1_a_q} - {s1_b_q[DATA_W-1], s1_b_q};
    end else begin
      addsub = {s1_a_q[DATA_W-1], s1_a_q} + {s1_b_q[DATA_W-1], s1_b_q};
    end

    prod_shift = s1_prod_q >>> FRAC_W;
    round_up   = (s1_prod_q[FRAC_W-1:0] > HALF) ||
                 ((s1_prod_q[FRAC_W-1:0] == HALF) && prod_shift[0]);
    rounded    = prod_shift + PROD_W'(round_up);
    mul_fits   = (&rounded[PROD_W-1:DATA_W-1]) || (~|rounded[PROD_W-1:DATA_W-1]);

    // Highest set bit wins, so scan upwards and keep the last hit.
    clz_cnt = DATA_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (s1_a_q[i]) clz_cnt = DATA_W'(DATA_W - 1 - i);
    end

    res     = '0;
    res_sat = 1'b0;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        res = addsub[DATA_W-1:0];
`ifdef FXP_ALU_SAT_EN
        if (addsub[DATA_W] != addsub[DATA_W-1]) begin
          res     = addsub[DATA_W] ? MIN_NEG : MAX_POS;
          res_sat = 1'b1;
        end
`endif
      end
      OP_MUL: begin
        res = rounded[DATA_W-1:0];
`ifdef FXP_ALU_SAT_EN
        if (!mul_fits) begin
          res     = s1_prod_q[PROD_W-1] ? MIN_NEG : MAX_POS;
          res_sat = 1'b1;
        end
`endif
      end
      OP_CLZ: res = clz_cnt;
      OP_MIN: res = ($signed(s1_b_q) < $signed(s1_a_q)) ? s1_b_q : s1_a_q;
      OP_MAX: res = ($signed(s1_b_q) > $signed(s1_a_q)) ? s1_b_q : s1_a_q;
      OP_ABS: begin
        res = s1_a_q[DATA_W-1] ? (~s1_a_q + 1'b1) : s1_a_q;
`ifdef FXP_ALU_SAT_EN
        if (s1_a_q == MIN_NEG) begin
          res     = MAX_POS;
          res_sat = 1'b1;
        end
`endif
      end
      default: begin
        res     = '0;
        res_sat = 1'b0;
      end
    endcase
  end

  // Stage 2 register control: bubbles leave the last result in place.
  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    sat_d       = sat_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d = res;
        sat_d  = res_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_prod_q   <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_prod_q   <= s1_prod_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready_o  = adv;
  assign out_valid_o = out_valid_q;
  assign data_o      = data_q;
  assign sat_o       = sat_q;

  // mul_fits only feeds the clamping path.
  logic unused_fits;
  assign unused_fits = mul_fits;

endmodule

`default_nettype wire

// File: tb/tb_fxp_alu_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_fxp_alu_pipe : self-checking bench for fxp_alu_pipe (DATA_W=16, FRAC_W=10)|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fxp_alu_pipe;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
`ifdef FXP_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  inst_i;
  logic [15:0] src_a_i;
  logic [15:0] src_b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] data_o;
  logic        sat_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  fxp_alu_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_i      (inst_i),
    .src_a_i     (src_a_i),
    .src_b_i     (src_b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .sat_o       (sat_o)
  );

  // Reference: integer arithmetic on the signed values, then clamp or wrap.
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    longint sa, sb, p, q, rem, r;
    bit     s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    s  = 1'b0;
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: begin
        p   = sa * sb;
        q   = p >>> FRAC_W;
        rem = p - (q <<< FRAC_W);
        if (rem > 512 || (rem == 512 && q[0])) q = q + 1;
        r = q;
      end
      3'd3: begin
        r = 16;
        for (int i = 15; i >= 0; i--) begin
          if (a[i]) begin
            r = 15 - i;
            break;
          end
        end
      end
      3'd4: r = (sb < sa) ? sb : sa;
      3'd5: r = (sb > sa) ? sb : sa;
      3'd6: r = (sa < 0) ? -sa : sa;
      default: r = 0;
    endcase
    if (SAT && (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd6)) begin
      if (r > 32767) begin
        r = 32767;
        s = 1'b1;
      end else if (r < -32768) begin
        r = -32768;
        s = 1'b1;
      end
    end
    return {s, r[15:0]};
  endfunction

  function automatic logic [15:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'($urandom_range(0, 40));
      4:       return 16'hFFFF - 16'($urandom_range(0, 40));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive, check handshake/output transfer, advance, check holds.
  task automatic step(input bit v, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input bit ordy, input bit use_model,
                      input logic [16:0] exp_c, output bit fired);
    logic [16:0] e;
    logic [15:0] held_data;
    logic        held_sat;
    bit          stalled;
    in_valid_i  = v;
    inst_i      = op;
    src_a_i     = a;
    src_b_i     = b;
    out_ready_i = ordy;
    #1;
    chk("in_ready", 32'(in_ready_o), 32'(!out_valid_o || ordy));
    fired = v && in_ready_o && !rst;
    if (out_valid_o && ordy && !rst) begin
      n_assert++;
      assert (exp_q.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_output observed=%0d expected=0", 1);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data_o", 32'(data_o), 32'(e[15:0]));
        chk("sat_o", 32'(sat_o), 32'(e[16]));
        n_out++;
      end
    end
    if (fired) exp_q.push_back(use_model ? model(op, a, b) : exp_c);
    stalled   = out_valid_o && !ordy && !rst;
    held_data = data_o;
    held_sat  = sat_o;
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
    if (stalled) begin
      chk("stall_valid_held", 32'(out_valid_o), 32'd1);
      chk("stall_data_held", 32'({held_sat, held_data}), 32'({sat_o, data_o}));
    end
  endtask

  task automatic idle(input bit ordy);
    bit f;
    step(1'b0, 3'd0, 16'h0, 16'h0, ordy, 1'b1, 17'h0, f);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit          f;
    int          idx;
    int          out0;
    logic [2:0]  d_op[12];
    logic [15:0] d_a[12];
    logic [15:0] d_b[12];
    logic [16:0] d_e[12];
    logic [2:0]  s_op[8];
    logic [15:0] s_a[8];
    logic [15:0] s_b[8];

    // Reset state
    rst = 1'b1; in_valid_i = 1'b0; inst_i = 3'd0;
    src_a_i = '0; src_b_i = '0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_sat", 32'(sat_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready_o), 32'd1);

    // Saturating add with exact 2-cycle latency
    step(1'b1, 3'd0, 16'h7000, 16'h2000, 1'b1, 1'b0,
         SAT ? 17'h17FFF : 17'h09000, f);
    chk("lat_cycle1_invalid", 32'(out_valid_o), 32'd0);
    idle(1'b1);
    chk("lat_cycle2_valid", 32'(out_valid_o), 32'd1);
    chk("add_sat_data", 32'(data_o), SAT ? 32'h7FFF : 32'h9000);
    chk("add_sat_flag", 32'(sat_o), SAT ? 32'd1 : 32'd0);

    // Directed corner cases with hand-derived results
    d_op[0]  = 3'd2; d_a[0]  = 16'h0600; d_b[0]  = 16'h0800; d_e[0]  = 17'h00C00;
    d_op[1]  = 3'd2; d_a[1]  = 16'h0001; d_b[1]  = 16'h0200; d_e[1]  = 17'h00000;
    d_op[2]  = 3'd2; d_a[2]  = 16'h0003; d_b[2]  = 16'h0200; d_e[2]  = 17'h00002;
    d_op[3]  = 3'd2; d_a[3]  = 16'h0000; d_b[3]  = 16'h8000; d_e[3]  = 17'h00000;
    d_op[4]  = 3'd3; d_a[4]  = 16'h0010; d_b[4]  = 16'h1234; d_e[4]  = 17'h0000B;
    d_op[5]  = 3'd3; d_a[5]  = 16'h0000; d_b[5]  = 16'hFFFF; d_e[5]  = 17'h00010;
    d_op[6]  = 3'd3; d_a[6]  = 16'h8000; d_b[6]  = 16'h0000; d_e[6]  = 17'h00000;
    d_op[7]  = 3'd6; d_a[7]  = 16'h8000; d_b[7]  = 16'h0000; d_e[7]  = SAT ? 17'h17FFF : 17'h08000;
    d_op[8]  = 3'd4; d_a[8]  = 16'hFFFF; d_b[8]  = 16'h0001; d_e[8]  = 17'h0FFFF;
    d_op[9]  = 3'd5; d_a[9]  = 16'hFFFF; d_b[9]  = 16'h0001; d_e[9]  = 17'h00001;
    d_op[10] = 3'd7; d_a[10] = 16'h1234; d_b[10] = 16'h5678; d_e[10] = 17'h00000;
    d_op[11] = 3'd2; d_a[11] = 16'h7FFF; d_b[11] = 16'h7FFF; d_e[11] = SAT ? 17'h17FFF : 17'h0FFC0;
    for (int k = 0; k < 12; k++) step(1'b1, d_op[k], d_a[k], d_b[k], 1'b1, 1'b0, d_e[k], f);
    step(1'b1, 3'd1, 16'h8000, 16'h0001, 1'b1, 1'b0, SAT ? 17'h18000 : 17'h07FFF, f);
    drain();

    // Back-to-back stream with a three-cycle consumer stall
    for (int k = 0; k < 8; k++) begin
      s_op[k] = 3'($urandom_range(0, 7));
      s_a[k]  = rnd_operand();
      s_b[k]  = rnd_operand();
    end
    idx  = 0;
    out0 = n_out;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      step(1'b1, s_op[idx], s_a[idx], s_b[idx], !(c >= 4 && c < 7), 1'b1, 17'h0, f);
      if (f) idx++;
    end
    chk("stream_accepted", 32'(idx), 32'd8);
    drain();
    chk("stream_delivered", 32'(n_out - out0), 32'd8);

    // Reset with two operations in flight
    out0 = n_out;
    step(1'b1, 3'd0, 16'h0001, 16'h0002, 1'b0, 1'b1, 17'h0, f);
    step(1'b1, 3'd2, 16'h0600, 16'h0800, 1'b0, 1'b1, 17'h0, f);
    rst = 1'b1;
    idle(1'b0);
    chk("flush_out_valid", 32'(out_valid_o), 32'd0);
    chk("flush_data", 32'(data_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("flush_ready", 32'(in_ready_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk("flush_no_output", 32'(out_valid_o), 32'd0);
    end
    chk("flush_nothing_delivered", 32'(n_out - out0), 32'd0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd_operand(),
           rnd_operand(), $urandom_range(0, 3) != 0, 1'b1, 17'h0, f);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fxp_alu_pipe.md
FXP_ALU_PIPE -- requirements
Module: fxp_alu_pipe

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the operand and result width in bits (range 8..32).
REQ-002 Parameter FRAC_W, default 10, SHALL set the number of fractional bits of signed fixed-point operands (1..DATA_W-2).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: synchronous reset, active-high.
REQ-005 Port in_valid_i, input, 1: the operation on the inputs is valid.
REQ-006 Port in_ready_o, output, 1: the block accepts an operation this cycle.
REQ-007 Port inst_i, input, 3: opcode. 0 add, 1 sub, 2 mul, 3 clz, 4 min, 5 max, 6 abs, 7 reserved.
REQ-008 Port src_a_i, input, DATA_W: operand A (two's complement).
REQ-009 Port src_b_i, input, DATA_W: operand B (two's complement).
REQ-010 Port out_valid_o, output, 1: the result is valid.
REQ-011 Port out_ready_i, input, 1: the consumer accepts the result.
REQ-012 Port data_o, output, DATA_W: the result.
REQ-013 Port sat_o, output, 1: the result was clamped to a saturation bound.

Function
REQ-014 Handshake: an input transfer SHALL occur when in_valid_i && in_ready_o; an output transfer SHALL occur when out_valid_o && out_ready_i.
REQ-015 Pipeline: two register stages (S1 operand/raw result, S2 rounded/saturated result); latency from accept to out_valid_o SHALL be exactly 2 cycles with no stall.
REQ-016 Advance enable SHALL be adv = !out_valid_o || out_ready_i; in_ready_o = adv; with adv low, both stages and data_o/sat_o SHALL hold unchanged.
REQ-017 With adv high, sustained throughput SHALL be one operation per cycle; bubbles SHALL propagate as invalid stages.
REQ-018 add/sub SHALL be computed at DATA_W+1 bits; on overflow the result SHALL be 0x7F..F (positive) or 0x80..0 (negative), with sat_o=1.
REQ-019 mul SHALL form the full 2*DATA_W-bit signed product and take bits [FRAC_W+DATA_W-1:FRAC_W].
REQ-019a mul rounding SHALL be round-half-to-even on the discarded FRAC_W bits.
REQ-019b mul saturation: if the rounded value does not fit DATA_W signed bits, the result SHALL clamp to the bound matching the product sign, with sat_o=1; a zero operand SHALL never saturate.
REQ-020 clz SHALL return the count of leading zeros of src_a_i, zero-extended to DATA_W; all-zero input SHALL return DATA_W.
REQ-021 min/max SHALL compare signed; equal operands SHALL return src_a_i.
REQ-022 abs of src_a_i: the most negative value SHALL return 0x7F..F with sat_o=1.
REQ-023 The reserved opcode SHALL return data 0 and sat_o=0, and SHALL still produce one output transfer.
REQ-024 sat_o SHALL be 0 for clz, min and max.

Reset
REQ-025 While rst=1 at a clock edge, stage valids, out_valid_o, data_o and sat_o SHALL clear to 0.
REQ-026 Operations in flight when reset is asserted SHALL be discarded without producing an output.
REQ-027 in_ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 Macro FXP_ALU_SAT_EN SHALL select overflow behaviour.
REQ-028a With FXP_ALU_SAT_EN defined, REQ-018, REQ-019b and REQ-022 clamping SHALL apply.
REQ-028b Without FXP_ALU_SAT_EN, add/sub/mul/abs SHALL wrap modulo 2^DATA_W, sat_o SHALL be tied to 0, and rounding SHALL be unchanged.

Verification (DATA_W=16, FRAC_W=10, FXP_ALU_SAT_EN defined unless stated)
REQ-029 add 0x7000 + 0x2000 -> data_o 0x7FFF, sat_o=1, 2 cycles after accept. Same stimulus without the macro -> 0x9000, sat_o=0.
REQ-030 mul cases, each with sat_o=0:
  - 0x0600 * 0x0800 -> 0x0C00
  - 0x0001 * 0x0200 -> 0x0000 (tie, even)
  - 0x0003 * 0x0200 -> 0x0002 (tie, round up to even)
  - 0x0000 * 0x8000 -> 0x0000
REQ-031 clz: 0x0010 -> 0x000B; 0x0000 -> 0x0010; 0x8000 -> 0x0000. abs 0x8000 -> 0x7FFF, sat_o=1.
REQ-032 Back-to-back stream of 8 ops, out_ready_i low for 3 cycles mid-stream -> in_ready_o low for those cycles, data_o held stable, all 8 results delivered in order, none lost or duplicated.
REQ-033 Reset asserted one cycle after accepting 2 ops -> out_valid_o=0 next cycle, no result for either op, in_ready_o=1 after release.
